hdlc_tx_scheduler: RTL and testbench

Two-requester frame scheduler in front of the HDLC core's Tx path. It grants one requester at a time using round-robin and streams that requester's bytes into the Tx buffer over the core's register bus. It then starts transmission, waits for completion or an abort, and reports per-frame status. It is the only master of the Tx register addresses; the Rx path is untouched.

---
 rtl/hdlc_tx_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_hdlc_tx_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx_scheduler.sv
// Two-requester round-robin frame scheduler for the HDLC Tx path.
// Grants one requester at a time, copies its bytes into the core Tx buffer
// over the register bus, starts transmission and reports per-frame status.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no owner; arbitrate between requesters
// LOAD     | stream owner bytes into the Tx buffer
// START    | issue Tx_Enable write
// WAIT_TX  | transmission in progress; wait for Tx_Done or owner abort
// ABORT    | issue Tx_AbortFrame write for an in-flight transmission
// WAIT_ABT | wait for the core to acknowledge the abort
// DRAIN    | frame too long; swallow remaining bytes up to Last
// FLUSH    | issue Tx_AbortFrame write to discard buffered bytes
// DONE     | status pulse, release grant, update round-robin pointer
module hdlc_tx_scheduler #(
    parameter int unsigned MAX_BYTES   = 126,
    parameter logic [2:0]  TXSC_ADDR   = 3'd0,
    parameter logic [2:0]  TXBUFF_ADDR = 3'd1
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [1:0]      Req_Valid,
    input  logic [1:0][7:0] Req_Data,
    input  logic [1:0]      Req_Last,
    input  logic [1:0]      Req_Abort,
    output logic [1:0]      Req_Ready,
    output logic [1:0]      Grant,
    input  logic            Tx_Full,
    input  logic            Tx_Done,
    input  logic            Tx_AbortedTrans,
    output logic [2:0]      Address,
    output logic            WriteEnable,
    output logic [7:0]      DataIn,
    output logic            Frame_Done,
    output logic            Frame_Aborted,
    output logic            Frame_SizeErr,
    output logic            Busy
);

    localparam int unsigned     CW          = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0]   MAX_CNT     = CW'(MAX_BYTES);
    localparam logic [7:0]      CMD_ENABLE  = 8'h02;
    localparam logic [7:0]      CMD_ABORT   = 8'h04;
    // Tx_Done is not trusted for the first two WAIT_TX cycles; the core may
    // still report the previous empty state right after Tx_Enable.
    localparam logic [1:0]      WAIT_IGNORE = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_TX,
        S_ABORT,
        S_WAIT_ABT,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_DONE,
        ST_ABORTED,
        ST_SIZEERR
    } status_t;

    state_t        state_q, state_d;
    status_t       status_q, status_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    wait_q, wait_d;
    logic          size_err_q, size_err_d;
    logic          we_q, we_d;
    logic [2:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;

    logic          owner;
    logic          accept;
    logic          pick;
    logic [CW-1:0] count_inc;

    assign owner     = grant_q[1];
    assign accept    = Req_Valid[owner] & Req_Ready[owner];
    assign count_inc = count_q + CW'(1);

    // Byte accept for the owner only: LOAD is throttled by buffer space and
    // capacity, DRAIN accepts everything so the requester can finish its frame.
    always_comb begin
        Req_Ready = 2'b00;
        if (state_q == S_LOAD) begin
            Req_Ready[owner] = !Tx_Full && (count_q < MAX_CNT);
        end else if (state_q == S_DRAIN) begin
            Req_Ready[owner] = 1'b1;
        end
    end

    // Next-state, datapath and registered bus write selection.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        grant_d    = grant_q;
        last_d     = last_q;
        count_d    = count_q;
        wait_d     = wait_q;
        size_err_d = size_err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        pick       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req_Valid != 2'b00) begin
                    if (Req_Valid == 2'b11) begin
                        pick = ~last_q;
                    end else begin
                        pick = Req_Valid[1];
                    end
                    grant_d    = pick ? 2'b10 : 2'b01;
                    count_d    = '0;
                    size_err_d = 1'b0;
                    status_d   = ST_NONE;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = TXBUFF_ADDR;
                    din_d   = Req_Data[owner];
                    count_d = count_inc;
                end
                if (Req_Abort[owner]) begin
                    state_d = S_FLUSH;
                end else if (accept && Req_Last[owner]) begin
                    state_d = S_START;
                end else if (accept && (count_inc == MAX_CNT)) begin
                    state_d = S_DRAIN;
                end
            end
            S_START: begin
                we_d    = 1'b1;
                addr_d  = TXSC_ADDR;
                din_d   = CMD_ENABLE;
                wait_d  = WAIT_IGNORE;
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (Req_Abort[owner]) begin
                    state_d = S_ABORT;
                end else if (wait_q != 2'd0) begin
                    wait_d = wait_q - 2'd1;
                end else if (Tx_Done) begin
                    status_d = ST_DONE;
                    state_d  = S_DONE;
                end
            end
            S_ABORT: begin
                we_d    = 1'b1;
                addr_d  = TXSC_ADDR;
                din_d   = CMD_ABORT;
                state_d = S_WAIT_ABT;
            end
            S_WAIT_ABT: begin
                if (Tx_AbortedTrans) begin
                    status_d = ST_ABORTED;
                    state_d  = S_DONE;
                end
            end
            S_DRAIN: begin
                if (Req_Abort[owner]) begin
                    state_d = S_FLUSH;
                end else if (accept && Req_Last[owner]) begin
                    size_err_d = 1'b1;
                    state_d    = S_FLUSH;
                end
            end
            S_FLUSH: begin
                we_d     = 1'b1;
                addr_d   = TXSC_ADDR;
                din_d    = CMD_ABORT;
                status_d = size_err_q ? ST_SIZEERR : ST_ABORTED;
                state_d  = S_DONE;
            end
            S_DONE: begin
                grant_d = 2'b00;
                last_d  = owner;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame without a bus write.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= S_IDLE;
            status_q   <= ST_NONE;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            count_q    <= '0;
            wait_q     <= 2'd0;
            size_err_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 3'd0;
            din_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            size_err_q <= size_err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    assign Grant         = grant_q;
    assign WriteEnable   = we_q;
    assign Address       = addr_q;
    assign DataIn        = din_q;
    assign Busy          = (state_q != S_IDLE);
    assign Frame_Done    = (state_q == S_DONE) && (status_q == ST_DONE);
    assign Frame_Aborted = (state_q == S_DONE) && (status_q == ST_ABORTED);
    assign Frame_SizeErr = (state_q == S_DONE) && (status_q == ST_SIZEERR);

endmodule

// File: tb/tb_hdlc_tx_scheduler.sv
// Self-checking bench for hdlc_tx_scheduler: directed sequence with random
// frame contents, compared against a frame-level model of the bus traffic.
module tb_hdlc_tx_scheduler;

    localparam int MAXB = 126;

    logic            Clk;
    logic            Rst;
    logic [1:0]      Req_Valid;
    logic [1:0][7:0] Req_Data;
    logic [1:0]      Req_Last;
    logic [1:0]      Req_Abort;
    logic [1:0]      Req_Ready;
    logic [1:0]      Grant;
    logic            Tx_Full;
    logic            Tx_Done;
    logic            Tx_AbortedTrans;
    logic [2:0]      Address;
    logic            WriteEnable;
    logic [7:0]      DataIn;
    logic            Frame_Done;
    logic            Frame_Aborted;
    logic            Frame_SizeErr;
    logic            Busy;

    hdlc_tx_scheduler dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Req_Valid      (Req_Valid),
        .Req_Data       (Req_Data),
        .Req_Last       (Req_Last),
        .Req_Abort      (Req_Abort),
        .Req_Ready      (Req_Ready),
        .Grant          (Grant),
        .Tx_Full        (Tx_Full),
        .Tx_Done        (Tx_Done),
        .Tx_AbortedTrans(Tx_AbortedTrans),
        .Address        (Address),
        .WriteEnable    (WriteEnable),
        .DataIn         (DataIn),
        .Frame_Done     (Frame_Done),
        .Frame_Aborted  (Frame_Aborted),
        .Frame_SizeErr  (Frame_SizeErr),
        .Busy           (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_err    = 0;

    // Bus/status observations gathered by the monitor.
    logic [10:0] wq[$];
    int          wcyc[$];
    logic [1:0]  gq[$];
    int          cyc_n     = 0;
    int          done_cnt  = 0;
    int          abt_cnt   = 0;
    int          sz_cnt    = 0;
    int          multi_cnt = 0;
    int          prev_any  = 0;
    logic [1:0]  prev_grant = 2'b00;

    // Reference-model state.
    logic [10:0] exp_q[$];
    logic [7:0]  fb[0:199];
    int          exp_done = 0;
    int          exp_abt  = 0;
    int          exp_sz   = 0;

    // Monitor: record writes, grant starts and status pulses at the falling edge.
    always @(negedge Clk) begin
        int npulse;
        cyc_n++;
        if (WriteEnable) begin
            wq.push_back({Address, DataIn});
            wcyc.push_back(cyc_n);
        end
        npulse = int'(Frame_Done) + int'(Frame_Aborted) + int'(Frame_SizeErr);
        if (Frame_Done)    done_cnt++;
        if (Frame_Aborted) abt_cnt++;
        if (Frame_SizeErr) sz_cnt++;
        if (npulse > 1 || (npulse > 0 && prev_any > 0)) multi_cnt++;
        prev_any = npulse;
        if (Grant != 2'b00 && prev_grant == 2'b00) gq.push_back(Grant);
        prev_grant = Grant;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic rand_bytes(input int len);
        for (int i = 0; i < len; i++) fb[i] = 8'($urandom_range(0, 255));
    endtask

    // Expected bus traffic for one frame: kind 0 = transmitted,
    // 1 = aborted after start, 2 = oversize.
    task automatic build_exp(input int len, input int kind);
        int n;
        exp_q.delete();
        n = (len > MAXB) ? MAXB : len;
        for (int i = 0; i < n; i++) exp_q.push_back({3'd1, fb[i]});
        if (len > MAXB) exp_q.push_back({3'd0, 8'h04});
        else            exp_q.push_back({3'd0, 8'h02});
        if (kind == 1)  exp_q.push_back({3'd0, 8'h04});
    endtask

    task automatic compare_writes(input string tag, input int base);
        check({tag, "_wr_count"}, 32'(wq.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < wq.size())
                check($sformatf("%s_wr%0d", tag, i), 32'(wq[base + i]), 32'(exp_q[i]));
        end
    endtask

    // Present fb[0..len-1] on requester r, honouring Req_Ready; optional
    // 3-cycle Tx_Full burst once two bytes are in.
    task automatic send(input int r, input int len, input bit full_mode);
        int  idx  = 0;
        int  cyc  = 0;
        int  fcnt = 0;
        logic rdy;
        while (idx < len && cyc < 2000) begin
            Req_Valid[r] = 1'b1;
            Req_Data[r]  = fb[idx];
            Req_Last[r]  = (idx == len - 1);
            Tx_Full      = full_mode && (idx == 2) && (fcnt < 3);
            @(negedge Clk);
            rdy = Req_Ready[r];
            if (Tx_Full) begin
                check("full_ready", 32'(Req_Ready[r]), 32'd0);
                if (fcnt > 0) check("full_nowrite", 32'(WriteEnable), 32'd0);
                fcnt++;
            end
            @(posedge Clk);
            #1;
            if (rdy) idx++;
            cyc++;
        end
        check("send_complete", 32'(idx), 32'(len));
        Req_Valid[r] = 1'b0;
        Req_Last[r]  = 1'b0;
        Tx_Full      = 1'b0;
    endtask

    // Wait for a status pulse; kind bits: 1 done, 2 aborted, 4 size error.
    task automatic wait_pulse(input int max, output int lat, output int kind);
        bit found = 0;
        lat  = 0;
        kind = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge Clk);
            if (Frame_Done || Frame_Aborted || Frame_SizeErr) begin
                lat   = i;
                kind  = int'(Frame_Done) | (int'(Frame_Aborted) << 1) | (int'(Frame_SizeErr) << 2);
                found = 1;
            end
            @(posedge Clk);
            #1;
            if (found) break;
        end
    endtask

    task automatic run_normal(input string tag, input int r, input int len, input bit full_mode);
        int b, lat, kind;
        b = wq.size();
        build_exp(len, 0);
        send(r, len, full_mode);
        repeat (5) step();
        Tx_Done = 1'b1;
        wait_pulse(20, lat, kind);
        Tx_Done = 1'b0;
        exp_done++;
        check({tag, "_status"}, 32'(kind), 32'd1);
        check({tag, "_grant_idle"}, 32'(Grant), 32'd0);
        check({tag, "_busy_idle"}, 32'(Busy), 32'd0);
        compare_writes(tag, b);
    endtask

    initial begin
        int b, lat, kind, r, len;
        Rst             = 1'b0;
        Req_Valid       = 2'b00;
        Req_Data        = '0;
        Req_Last        = 2'b00;
        Req_Abort       = 2'b00;
        Tx_Full         = 1'b0;
        Tx_Done         = 1'b0;
        Tx_AbortedTrans = 1'b0;

        // Reset state.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_ready", 32'(Req_Ready), 32'd0);
        check("rst_we",    32'(WriteEnable), 32'd0);
        check("rst_addr",  32'(Address), 32'd0);
        check("rst_data",  32'(DataIn), 32'd0);
        check("rst_busy",  32'(Busy), 32'd0);
        check("rst_pulses", 32'({Frame_Done, Frame_Aborted, Frame_SizeErr}), 32'd0);

        // Both requesters valid from reset: one-byte frames, 0 wins first, then alternate.
        Req_Data[0] = 8'h50;
        Req_Data[1] = 8'h61;
        Req_Last    = 2'b11;
        Tx_Done     = 1'b1;
        @(posedge Clk);
        #1;
        Rst       = 1'b1;
        Req_Valid = 2'b11;
        b = wq.size();
        for (int i = 0; i < 100 && done_cnt < 4; i++) @(negedge Clk);
        Req_Valid = 2'b00;
        Req_Last  = 2'b00;
        step();
        Tx_Done = 1'b0;
        exp_done += 4;
        check("rr_frames", 32'(done_cnt), 32'd4);
        check("rr_grants", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check($sformatf("rr_grant%0d", i), 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({3'd1, (i % 2 == 0) ? 8'h50 : 8'h61});
            exp_q.push_back({3'd0, 8'h02});
        end
        compare_writes("rr", b);
        repeat (2) step();

        // Three-byte frame on requester 0: consecutive writes then Tx_Enable.
        fb[0] = 8'hA1; fb[1] = 8'hB2; fb[2] = 8'hC3;
        b = wq.size();
        run_normal("f3", 0, 3, 0);
        if (wcyc.size() >= b + 4)
            for (int i = 0; i < 3; i++)
                check($sformatf("f3_gap%0d", i), 32'(wcyc[b + i + 1] - wcyc[b + i]), 32'd1);
        step();

        // Tx_Done held high from the START cycle: START, write, two ignored
        // WAIT_TX cycles, accepting cycle, DONE => pulse on the 5th cycle.
        rand_bytes(4);
        b = wq.size();
        build_exp(4, 0);
        send(1, 4, 0);
        Tx_Done = 1'b1;
        wait_pulse(20, lat, kind);
        Tx_Done = 1'b0;
        exp_done++;
        check("lat_status", 32'(kind), 32'd1);
        check("lat_cycles", 32'(lat), 32'd5);
        compare_writes("lat", b);
        step();

        // Random frames, random owner, random Tx_Full bursts.
        for (int f = 0; f < 5; f++) begin
            r   = $urandom_range(0, 1);
            len = $urandom_range(4, 20);
            rand_bytes(len);
            run_normal($sformatf("rnd%0d", f), r, len, 1'($urandom_range(0, 1)));
            step();
        end

        // Explicit Tx_Full burst mid-load.
        rand_bytes(8);
        run_normal("full", 0, 8, 1);
        step();

        // Abort in WAIT_TX coinciding with Tx_Done.
        rand_bytes(5);
        b = wq.size();
        build_exp(5, 1);
        send(1, 5, 0);
        repeat (3) step();
        Req_Abort[1] = 1'b1;
        Tx_Done      = 1'b1;
        step();
        Req_Abort[1] = 1'b0;
        repeat (3) step();
        Tx_AbortedTrans = 1'b1;
        wait_pulse(20, lat, kind);
        Tx_AbortedTrans = 1'b0;
        Tx_Done         = 1'b0;
        exp_abt++;
        check("abt_status", 32'(kind), 32'd2);
        check("abt_latency", 32'(lat), 32'd2);
        compare_writes("abt", b);
        step();

        // 127-byte frame: 126 buffer writes, then discard and size error.
        rand_bytes(127);
        b = wq.size();
        build_exp(127, 2);
        send(1, 127, 0);
        wait_pulse(10, lat, kind);
        exp_sz++;
        check("big_status", 32'(kind), 32'd4);
        check("big_latency", 32'(lat), 32'd2);
        check("big_grant_idle", 32'(Grant), 32'd0);
        compare_writes("big", b);
        step();

        // Reset asserted during LOAD returns outputs at once, with no edge.
        b = wq.size();
        Req_Valid[0] = 1'b1;
        Req_Data[0]  = 8'h3C;
        Req_Last[0]  = 1'b0;
        for (int i = 0; i < 20 && (wq.size() - b) < 4; i++) step();
        check("rl_busy_before", 32'(Busy), 32'd1);
        #1;
        Rst = 1'b0;
        #1;
        check("rl_grant", 32'(Grant), 32'd0);
        check("rl_ready", 32'(Req_Ready), 32'd0);
        check("rl_we",    32'(WriteEnable), 32'd0);
        check("rl_addr",  32'(Address), 32'd0);
        check("rl_data",  32'(DataIn), 32'd0);
        check("rl_busy",  32'(Busy), 32'd0);
        Req_Valid[0] = 1'b0;
        step();
        Rst = 1'b1;
        step();

        // Fresh 126-byte frame after reset: legal maximum, transmits normally.
        rand_bytes(126);
        run_normal("max", 0, 126, 0);
        step();

        check("cnt_done",    32'(done_cnt), 32'(exp_done));
        check("cnt_aborted", 32'(abt_cnt), 32'(exp_abt));
        check("cnt_sizeerr", 32'(sz_cnt), 32'(exp_sz));
        check("pulse_shape", 32'(multi_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
